// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the screen compositor.
// Horizontal and vertical counters advance on each pixel enable. Coordinates,
// syncs, blanking, line/frame pulses and a frame counter are registered and
// decoded from the next counter values, so they line up with the counters.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_clk,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       f_wrap;
    logic       vis_next;
    logic       hs_next;
    logic       vs_next;

    // Next counter values; an out-of-range count is treated as terminal and wraps.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        h_wrap = 1'b0;
        f_wrap = 1'b0;
        if (pix_clk) begin
            if (h_cnt >= H_LAST) begin
                h_next = 10'd0;
                h_wrap = 1'b1;
                if (v_cnt >= V_LAST) begin
                    v_next = 10'd0;
                    f_wrap = 1'b1;
                end else begin
                    v_next = v_cnt + 10'd1;
                end
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end else begin
            h_next = h_cnt;
            v_next = v_cnt;
        end
    end

    // Decode visibility and sync windows from the next counter values.
    always_comb begin
        vis_next = (h_next < H_VIS) && (v_next < V_VIS);
        hs_next  = (h_next >= HS_BEG) && (h_next <= HS_END);
        vs_next  = (v_next >= VS_BEG) && (v_next <= VS_END);
    end

    // Counter and output registers; decoded outputs refresh only on an enable so
    // the reset values persist until the first pixel advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            frame_cnt   <= 8'd0;
            pix_x       <= 10'd0;
            pix_y       <= 9'd0;
            video_on    <= 1'b0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            line_start  <= h_wrap;
            frame_start <= f_wrap;
            if (f_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (pix_clk) begin
                video_on <= vis_next;
                pix_x    <= vis_next ? h_next : 10'd0;
                pix_y    <= vis_next ? v_next[8:0] : 9'd0;
                h_sync   <= hs_next ? SYNC_POL : ~SYNC_POL;
                v_sync   <= vs_next ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule
